// File: rtl/imem_pipe_if.sv
// imem_pipe_if
//   Fetch bus between the pipeline front end and the instruction memory.
//   Carries a valid/ready request channel (byte address) and a valid/ready
//   response channel (instruction word plus address-fault flag).
//
//   Parameters
//     N     instruction word width
//     PC_W  fetch byte address width
//
//   Modports
//     master  fetch unit side: drives req_valid/req_addr/rsp_ready
//     slave   memory side:     drives req_ready/rsp_valid/rsp_instr/rsp_err
interface imem_pipe_if #(
    parameter int N    = 32,
    parameter int PC_W = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [PC_W-1:0] req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [N-1:0]    rsp_instr;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/imem_pipe.sv
// imem_pipe
//   Writable instruction memory for the pipelined ARM core. Synchronous read
//   with LAT pipeline stages between an accepted fetch request and its
//   response, valid/ready handshake on both sides, and a whole-pipeline
//   freeze whenever the response is offered but not taken.
//   A side write port loads program words at run time; the array itself is
//   never touched by reset, so a program loaded before a reset survives it.
//
//   Parameters
//     N      instruction word width (bits)
//     DEPTH  number of words, power of 2, >= 2
//     PC_W   fetch byte address width
//     LAT    read latency in cycles, 1..4
//
//   Ports
//     clk        rising-edge clock for all state
//     reset      asynchronous, active-high; clears the pipeline, not the array
//     bus        imem_pipe_if.slave fetch request/response channel
//     prog_we    program-load write strobe
//     prog_addr  word index to write
//     prog_data  word to write
//
//   Build option
//     IMEM_BOUNDS_EN  when defined, misaligned or out-of-range fetch addresses
//                     return rsp_err=1 with rsp_instr=0; when undefined the
//                     address wraps modulo DEPTH and rsp_err is always 0.
module imem_pipe #(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    parameter int PC_W  = 64,
    parameter int LAT   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    imem_pipe_if.slave               bus,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [N-1:0]             prog_data
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]   mem [DEPTH];

    logic [LAT-1:0] stage_valid;
    logic [N-1:0]   stage_instr [LAT];
    logic [LAT-1:0] stage_err;

    logic           stall;
    logic           accept;
    logic           fault;
    logic [AW-1:0]  rd_idx;
    logic [N-1:0]   rd_word;

    // A response sitting at the output that the consumer refuses freezes
    // every stage, bubbles included, so nothing can be overwritten or lost.
    // req_ready is deliberately independent of req_valid.
    assign stall         = bus.rsp_valid & ~bus.rsp_ready;
    assign bus.req_ready = ~stall;
    assign accept        = bus.req_valid & ~stall;

    assign rd_idx = bus.req_addr[2 +: AW];

`ifdef IMEM_BOUNDS_EN
    // Any set byte-offset bit or any address bit above the array range faults;
    // a faulting request carries a zero word instead of array data.
    assign fault   = (bus.req_addr[1:0] != 2'b00)
                   | (bus.req_addr[PC_W-1:2+AW] != '0);
    assign rd_word = fault ? '0 : mem[rd_idx];
`else
    // Without bounds checking the offset and upper bits are simply dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[PC_W-1:2+AW]};
    assign fault   = 1'b0;
    assign rd_word = mem[rd_idx];
`endif

    // Program-load port. Independent of the fetch pipeline and of reset.
    // Because stage 1 samples mem with the pre-edge value, a write and a read
    // of the same index in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Read pipeline. Stage 0 captures the array word on accept (or a bubble
    // when nothing is accepted); later stages shift one per cycle. Stage data
    // is kept on a bubble so rsp_instr only moves when a stage actually shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= '0;
            stage_err   <= '0;
            for (int k = 0; k < LAT; k++) begin
                stage_instr[k] <= '0;
            end
        end else if (!stall) begin
            stage_valid[0] <= accept;
            if (accept) begin
                stage_instr[0] <= rd_word;
                stage_err[0]   <= fault;
            end
            for (int k = 1; k < LAT; k++) begin
                stage_valid[k] <= stage_valid[k-1];
                stage_instr[k] <= stage_instr[k-1];
                stage_err[k]   <= stage_err[k-1];
            end
        end
    end

    // Outputs come straight from the last stage registers, so an async reset
    // clears them without waiting for a clock edge.
    assign bus.rsp_valid = stage_valid[LAT-1];
    assign bus.rsp_instr = stage_instr[LAT-1];
    assign bus.rsp_err   = stage_err[LAT-1];

endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe
//   Self-checking bench for imem_pipe. Two instances share the program-load
//   port: dut1 with LAT=1 and dut3 with LAT=3. Accepted requests push their
//   expected response (from a bench-side memory model) into a per-instance
//   queue; responses taken by the consumer are popped and compared. Directed
//   checks cover latency, stall behaviour, read-first writes, async reset and
//   address handling (bounds-checked or wrapping depending on IMEM_BOUNDS_EN).
module tb_imem_pipe;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;

    int          total;
    int          bad;

    logic [31:0] model [64];
    rsp_t        q1 [$];
    rsp_t        q3 [$];
    logic [31:0] prog_words [4];

    imem_pipe_if #(.N(32), .PC_W(64)) if1 ();
    imem_pipe_if #(.N(32), .PC_W(64)) if3 ();

    imem_pipe #(.N(32), .DEPTH(64), .PC_W(64), .LAT(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if1),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    imem_pipe #(.N(32), .DEPTH(64), .PC_W(64), .LAT(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .bus       (if3),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench copy of the array, written with the same edge semantics.
    always @(posedge clk) begin
        if (prog_we) begin
            model[prog_addr] <= prog_data;
        end
    end

    function automatic rsp_t expect_for(input logic [63:0] a);
        rsp_t r;
        r.err   = 1'b0;
        r.instr = model[a[7:2]];
`ifdef IMEM_BOUNDS_EN
        if (a[1:0] != 2'b00 || a[63:8] != 56'd0) begin
            r.err   = 1'b1;
            r.instr = 32'd0;
        end
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of fetch-side inputs on the selected instance, then
    // advance to 1 time unit past the next rising edge.
    task automatic applyStimulus(input int which, input logic valid,
                                 input logic [63:0] addr, input logic ready);
        if (which == 1) begin
            if1.req_valid = valid;
            if1.req_addr  = addr;
            if1.rsp_ready = ready;
        end else begin
            if3.req_valid = valid;
            if3.req_addr  = addr;
            if3.rsp_ready = ready;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [5:0] idx, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = idx;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
    endtask

    // Scoreboards: sampled mid-cycle, where all inputs and registered outputs
    // are stable; what is seen here is what the next rising edge transfers.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            if (if1.req_valid && if1.req_ready) q1.push_back(expect_for(if1.req_addr));
            if (if1.rsp_valid && if1.rsp_ready) begin
                checkOutput("sb1_pending", 64'(q1.size() > 0), 64'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    checkOutput("sb1_instr", 64'(if1.rsp_instr), 64'(e.instr));
                    checkOutput("sb1_err", 64'(if1.rsp_err), 64'(e.err));
                end
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            if (if3.req_valid && if3.req_ready) q3.push_back(expect_for(if3.req_addr));
            if (if3.rsp_valid && if3.rsp_ready) begin
                checkOutput("sb3_pending", 64'(q3.size() > 0), 64'd1);
                if (q3.size() > 0) begin
                    e = q3.pop_front();
                    checkOutput("sb3_instr", 64'(if3.rsp_instr), 64'(e.instr));
                    checkOutput("sb3_err", 64'(if3.rsp_err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        prog_words[0] = 32'hf8000001;
        prog_words[1] = 32'hf8008002;
        prog_words[2] = 32'hf8000203;
        prog_words[3] = 32'h8b050083;
        for (int i = 0; i < 64; i++) model[i] = 32'd0;

        reset         = 1'b1;
        prog_we       = 1'b0;
        prog_addr     = '0;
        prog_data     = '0;
        if1.req_valid = 1'b0;
        if1.req_addr  = '0;
        if1.rsp_ready = 1'b1;
        if3.req_valid = 1'b0;
        if3.req_addr  = '0;
        if3.rsp_ready = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rst_valid1", 64'(if1.rsp_valid), 64'd0);
        checkOutput("rst_instr1", 64'(if1.rsp_instr), 64'd0);
        checkOutput("rst_err1", 64'(if1.rsp_err), 64'd0);
        checkOutput("rst_valid3", 64'(if3.rsp_valid), 64'd0);
        checkOutput("rst_ready1", 64'(if1.req_ready), 64'd1);
        reset = 1'b0;

        // Program load
        for (int i = 0; i < 4; i++) writeWord(6'(i), prog_words[i]);
        writeWord(6'd63, 32'h0badf00d);

        // LAT=1 back-to-back fetch, one response per cycle
        $display("[TB] LAT=1 streaming");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1'b1, 64'(i * 4), 1'b1);
            checkOutput("t1_valid", 64'(if1.rsp_valid), 64'd1);
            checkOutput("t1_instr", 64'(if1.rsp_instr), 64'(prog_words[i]));
        end
        applyStimulus(1, 1'b0, 64'd0, 1'b1);
        checkOutput("t1_drain", 64'(if1.rsp_valid), 64'd0);

        // LAT=3 with a 5-cycle stall on the first response
        $display("[TB] LAT=3 stall");
        applyStimulus(3, 1'b1, 64'd0, 1'b0);
        checkOutput("t2_lat_not1", 64'(if3.rsp_valid), 64'd0);
        applyStimulus(3, 1'b1, 64'd4, 1'b0);
        applyStimulus(3, 1'b1, 64'd8, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("t2_stall_ready", 64'(if3.req_ready), 64'd0);
            checkOutput("t2_stall_valid", 64'(if3.rsp_valid), 64'd1);
            checkOutput("t2_hold", 64'(if3.rsp_instr), 64'h0f8000001);
            applyStimulus(3, 1'b1, 64'd12, 1'b0);
        end
        applyStimulus(3, 1'b0, 64'd0, 1'b1);
        checkOutput("t2_second", 64'(if3.rsp_instr), 64'h0f8008002);
        applyStimulus(3, 1'b0, 64'd0, 1'b1);
        checkOutput("t2_third", 64'(if3.rsp_instr), 64'h0f8000203);
        applyStimulus(3, 1'b0, 64'd0, 1'b1);
        checkOutput("t2_drain", 64'(if3.rsp_valid), 64'd0);

        // Read-first on same-cycle write, then new word visible
        $display("[TB] read-first write");
        prog_we   = 1'b1;
        prog_addr = 6'd2;
        prog_data = 32'hcb050083;
        applyStimulus(1, 1'b1, 64'd8, 1'b1);
        prog_we   = 1'b0;
        checkOutput("t3_old_word", 64'(if1.rsp_instr), 64'h0f8000203);
        applyStimulus(1, 1'b1, 64'd8, 1'b1);
        checkOutput("t3_new_word", 64'(if1.rsp_instr), 64'h0cb050083);
        applyStimulus(1, 1'b0, 64'd0, 1'b1);

        // Write to a word already in flight in the LAT=3 pipeline
        applyStimulus(3, 1'b1, 64'd0, 1'b1);
        prog_we   = 1'b1;
        prog_addr = 6'd0;
        prog_data = 32'h12345678;
        applyStimulus(3, 1'b0, 64'd0, 1'b1);
        prog_we   = 1'b0;
        applyStimulus(3, 1'b0, 64'd0, 1'b1);
        checkOutput("t3_inflight", 64'(if3.rsp_instr), 64'h0f8000001);
        applyStimulus(3, 1'b0, 64'd0, 1'b1);

        // Async reset during a stall
        $display("[TB] reset mid-stall");
        applyStimulus(3, 1'b1, 64'd4, 1'b0);
        applyStimulus(3, 1'b0, 64'd0, 1'b0);
        applyStimulus(3, 1'b0, 64'd0, 1'b0);
        checkOutput("t4_pre_valid", 64'(if3.rsp_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t4_async_valid", 64'(if3.rsp_valid), 64'd0);
        checkOutput("t4_async_instr", 64'(if3.rsp_instr), 64'd0);
        checkOutput("t4_async_err", 64'(if3.rsp_err), 64'd0);
        q3.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(3, 1'b1, 64'd4, 1'b1);
        applyStimulus(3, 1'b0, 64'd0, 1'b1);
        checkOutput("t4_cold", 64'(if3.rsp_valid), 64'd0);
        applyStimulus(3, 1'b0, 64'd0, 1'b1);
        checkOutput("t4_kept_valid", 64'(if3.rsp_valid), 64'd1);
        checkOutput("t4_kept_instr", 64'(if3.rsp_instr), 64'h0f8008002);
        applyStimulus(3, 1'b0, 64'd0, 1'b1);

        // Address handling
        $display("[TB] address handling");
`ifdef IMEM_BOUNDS_EN
        applyStimulus(1, 1'b1, 64'h100, 1'b1);
        checkOutput("t5_range_err", 64'(if1.rsp_err), 64'd1);
        checkOutput("t5_range_instr", 64'(if1.rsp_instr), 64'd0);
        applyStimulus(1, 1'b1, 64'h2, 1'b1);
        checkOutput("t5_align_err", 64'(if1.rsp_err), 64'd1);
        checkOutput("t5_align_instr", 64'(if1.rsp_instr), 64'd0);
        applyStimulus(1, 1'b1, 64'd252, 1'b1);
        checkOutput("t5_top_err", 64'(if1.rsp_err), 64'd0);
        checkOutput("t5_top_instr", 64'(if1.rsp_instr), 64'h00badf00d);
`else
        applyStimulus(1, 1'b1, 64'h104, 1'b1);
        checkOutput("t6_wrap_instr", 64'(if1.rsp_instr), 64'h0f8008002);
        checkOutput("t6_wrap_err", 64'(if1.rsp_err), 64'd0);
        applyStimulus(1, 1'b1, 64'd252, 1'b1);
        checkOutput("t6_top_instr", 64'(if1.rsp_instr), 64'h00badf00d);
`endif
        applyStimulus(1, 1'b0, 64'd0, 1'b1);

        applyStimulus(1, 1'b0, 64'd0, 1'b1);
        checkOutput("q1_empty", 64'(q1.size()), 64'd0);
        checkOutput("q3_empty", 64'(q3.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
